// File: rtl/kugelblitz_tx_pad.sv
// kugelblitz_tx_pad: per-channel AXIS TX conditioner (byte masking, runt padding, output register).
// Define KUGELBLITZ_TX_PAD_STATS_EN to build the per-channel padded-frame counters on pad_count.
module kugelblitz_tx_pad #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned MIN_FRAME_LEN = 60
) (
  input  logic                           tx_clk,
  input  logic                           tx_rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [CHANNELS-1:0]            m_axis_tvalid,
  input  logic [CHANNELS-1:0]            m_axis_tready,
  output logic [CHANNELS-1:0]            m_axis_tlast,
  output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser,
  output logic [CHANNELS*32-1:0]         pad_count
);

  localparam int unsigned CW = $clog2(MIN_FRAME_LEN + 1);
  localparam logic ST_PASS = 1'b0;
  localparam logic ST_PAD  = 1'b1;

  function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [31:0] n;
    n = '0;
    for (int unsigned k = 0; k < KEEP_WIDTH; k++) n = n + 32'(keep[k]);
    return n;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [31:0] need);
    logic [KEEP_WIDTH-1:0] m;
    for (int unsigned k = 0; k < KEEP_WIDTH; k++) m[k] = (k < need);
    return m;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [31:0] inc);
    logic [31:0] s;
    s = 32'(cnt) + inc;
    return (s >= MIN_FRAME_LEN) ? CW'(MIN_FRAME_LEN) : CW'(s);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  r_state;
    logic [CW-1:0]         r_cnt;
    logic [USER_WIDTH-1:0] r_user;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_valid;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_muser;

    logic [DATA_WIDTH-1:0] w_in_data;
    logic [KEEP_WIDTH-1:0] w_in_keep;
    logic [USER_WIDTH-1:0] w_in_user;
    logic [DATA_WIDTH-1:0] w_masked;
    logic [31:0]           w_pop;
    logic [31:0]           w_need;
    logic                  w_free;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_short;
    logic                  w_fits;

    assign w_in_data = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_keep = s_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
    assign w_in_user = s_axis_tuser[c*USER_WIDTH +: USER_WIDTH];
    assign w_free    = !r_valid || m_axis_tready[c];
    assign w_ready   = (r_state == ST_PASS) && w_free;
    assign w_accept  = w_ready && s_axis_tvalid[c];
    assign w_pop     = popcount(w_in_keep);
    // r_cnt never exceeds MIN_FRAME_LEN, so need cannot underflow.
    assign w_need    = 32'(MIN_FRAME_LEN) - 32'(r_cnt);
    assign w_short   = w_pop < w_need;
    assign w_fits    = w_need <= KEEP_WIDTH;

    always_comb begin
      w_masked = '0;
      for (int unsigned k = 0; k < KEEP_WIDTH; k++) begin
        if (w_in_keep[k]) w_masked[k*8 +: 8] = w_in_data[k*8 +: 8];
      end
    end

    always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
        r_state <= ST_PASS;
        r_cnt   <= '0;
        r_user  <= '0;
        r_data  <= '0;
        r_keep  <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_muser <= '0;
      end else if (r_state == ST_PASS) begin
        if (w_accept) begin
          r_valid <= 1'b1;
          r_data  <= w_masked;
          if (!s_axis_tlast[c]) begin
            r_keep  <= w_in_keep;
            r_last  <= 1'b0;
            r_muser <= w_in_user;
            r_cnt   <= sat_add(r_cnt, w_pop);
          end else if (!w_short) begin
            r_keep  <= w_in_keep;
            r_last  <= 1'b1;
            r_muser <= w_in_user;
            r_cnt   <= '0;
          end else if (w_fits) begin
            r_keep  <= keep_mask(w_need);
            r_last  <= 1'b1;
            r_muser <= w_in_user;
            r_cnt   <= '0;
          end else begin
            // Padding spills into further beats; tuser rides on the final pad beat.
            r_keep  <= '1;
            r_last  <= 1'b0;
            r_muser <= '0;
            r_user  <= w_in_user;
            r_cnt   <= sat_add(r_cnt, KEEP_WIDTH);
            r_state <= ST_PAD;
          end
        end else if (m_axis_tready[c]) begin
          r_valid <= 1'b0;
        end
      end else if (w_free) begin
        r_valid <= 1'b1;
        r_data  <= '0;
        if (w_fits) begin
          r_keep  <= keep_mask(w_need);
          r_last  <= 1'b1;
          r_muser <= r_user;
          r_cnt   <= '0;
          r_state <= ST_PASS;
        end else begin
          r_keep  <= '1;
          r_last  <= 1'b0;
          r_muser <= '0;
          r_cnt   <= sat_add(r_cnt, KEEP_WIDTH);
        end
      end
    end

    assign s_axis_tready[c]                          = w_ready;
    assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]  = r_data;
    assign m_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]  = r_keep;
    assign m_axis_tvalid[c]                          = r_valid;
    assign m_axis_tlast[c]                           = r_last;
    assign m_axis_tuser[c*USER_WIDTH +: USER_WIDTH]  = r_muser;

`ifdef KUGELBLITZ_TX_PAD_STATS_EN
    logic [31:0] r_pad_cnt;
    always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
        r_pad_cnt <= '0;
      end else if (w_accept && s_axis_tlast[c] && w_short) begin
        r_pad_cnt <= r_pad_cnt + 32'd1;
      end
    end
    assign pad_count[c*32 +: 32] = r_pad_cnt;
`else
    assign pad_count[c*32 +: 32] = '0;
`endif
  end

endmodule

// File: tb/tb_kugelblitz_tx_pad.sv
// Directed bench for kugelblitz_tx_pad: a 1x512-bit instance (a_*) and a 2x64-bit instance (b_*).
module tb_kugelblitz_tx_pad;
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  logic [511:0] a_s_data, a_m_data;
  logic [63:0]  a_s_keep, a_m_keep;
  logic         a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
  logic [0:0]   a_s_user, a_m_user;
  logic [31:0]  a_pad;

  logic [127:0] b_s_data, b_m_data;
  logic [15:0]  b_s_keep, b_m_keep;
  logic [1:0]   b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic [1:0]   b_s_user, b_m_user;
  logic [63:0]  b_pad;

  int n_vec;
  int n_fail;

  kugelblitz_tx_pad #(
    .CHANNELS(1), .DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(1), .MIN_FRAME_LEN(60)
  ) u_dut_a (
    .tx_clk(clk), .tx_rst(rst_a),
    .s_axis_tdata(a_s_data), .s_axis_tkeep(a_s_keep), .s_axis_tvalid(a_s_valid),
    .s_axis_tready(a_s_ready), .s_axis_tlast(a_s_last), .s_axis_tuser(a_s_user),
    .m_axis_tdata(a_m_data), .m_axis_tkeep(a_m_keep), .m_axis_tvalid(a_m_valid),
    .m_axis_tready(a_m_ready), .m_axis_tlast(a_m_last), .m_axis_tuser(a_m_user),
    .pad_count(a_pad)
  );

  kugelblitz_tx_pad #(
    .CHANNELS(2), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1), .MIN_FRAME_LEN(60)
  ) u_dut_b (
    .tx_clk(clk), .tx_rst(rst_b),
    .s_axis_tdata(b_s_data), .s_axis_tkeep(b_s_keep), .s_axis_tvalid(b_s_valid),
    .s_axis_tready(b_s_ready), .s_axis_tlast(b_s_last), .s_axis_tuser(b_s_user),
    .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tvalid(b_m_valid),
    .m_axis_tready(b_m_ready), .m_axis_tlast(b_m_last), .m_axis_tuser(b_m_user),
    .pad_count(b_pad)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] exp_d, hold_d;
    logic [511:0] beat_d [3];
    logic [511:0] got_d [3];
    logic [63:0]  beat_k [3];
    logic [63:0]  got_k [3];
    logic         got_l [3];
    logic [63:0]  hold_k;
    logic         hold_l, stall;
    int           in_i, out_i, frames, out_last, out_beats;

    n_vec = 0;
    n_fail = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    a_s_data = '0; a_s_keep = '0; a_s_valid = 1'b0; a_s_last = 1'b0; a_s_user = '0;
    a_m_ready = 1'b1;
    b_s_data = '0; b_s_keep = '0; b_s_valid = '0; b_s_last = '0; b_s_user = '0;
    b_m_ready = 2'b11;
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    check("a_rst_valid", 512'(a_m_valid), 512'(1'b0));
    check("a_rst_data", a_m_data, 512'(0));
    check("a_rst_keep", 512'(a_m_keep), 512'(0));
    check("a_rst_pad", 512'(a_pad), 512'(0));
    check("a_rst_ready", 512'(a_s_ready), 512'(1'b1));
    check("b_rst_valid", 512'(b_m_valid), 512'(2'b00));
    check("b_rst_pad", 512'(b_pad), 512'(0));

    // 512-bit single runt beat: 40 bytes + 0xAA garbage -> padded to 60 in one beat
    exp_d = '0;
    for (int k = 0; k < 64; k++) begin
      a_s_data[k*8 +: 8] = (k < 40) ? 8'(k + 1) : 8'hAA;
      if (k < 40) exp_d[k*8 +: 8] = 8'(k + 1);
    end
    a_s_keep = {24'h0, {40{1'b1}}};
    a_s_last = 1'b1; a_s_user = 1'b0; a_s_valid = 1'b1;
    tick();
    a_s_valid = 1'b0; a_s_last = 1'b0;
    check("a1_valid", 512'(a_m_valid), 512'(1'b1));
    check("a1_data", a_m_data, exp_d);
    check("a1_keep", 512'(a_m_keep), 512'({4'h0, {60{1'b1}}}));
    check("a1_last", 512'(a_m_last), 512'(1'b1));
    check("a1_user", 512'(a_m_user), 512'(1'b0));
    check("a1_pad", 512'(a_pad), 512'(StatsEn ? 32'd1 : 32'd0));
    tick();
    check("a1_idle", 512'(a_m_valid), 512'(1'b0));

    // 64-bit 24-byte frame, tuser=1 on last -> 8 beats out
    b_s_keep = 16'h00FF; b_s_valid = 2'b01; b_s_last = 2'b00; b_s_user = 2'b00;
    b_s_data[63:0] = 64'h0807060504030201;
    tick();
    check("b2_b0_data", 512'(b_m_data[63:0]), 512'(64'h0807060504030201));
    check("b2_b0_user", 512'(b_m_user[0]), 512'(1'b0));
    b_s_data[63:0] = 64'h100F0E0D0C0B0A09;
    tick();
    check("b2_b1_data", 512'(b_m_data[63:0]), 512'(64'h100F0E0D0C0B0A09));
    b_s_data[63:0] = 64'h1817161514131211;
    b_s_last = 2'b01; b_s_user = 2'b01;
    tick();
    b_s_valid = 2'b00; b_s_last = 2'b00; b_s_user = 2'b00;
    check("b2_b2_data", 512'(b_m_data[63:0]), 512'(64'h1817161514131211));
    check("b2_b2_keep", 512'(b_m_keep[7:0]), 512'(8'hFF));
    check("b2_b2_last", 512'(b_m_last[0]), 512'(1'b0));
    check("b2_b2_user", 512'(b_m_user[0]), 512'(1'b0));
    check("b2_b2_ready", 512'(b_s_ready[0]), 512'(1'b0));
    // Pad beats 3..7 are generated while the input is held off
    for (int k = 3; k < 8; k++) begin
      tick();
      check("b2_pad_valid", 512'(b_m_valid[0]), 512'(1'b1));
      check("b2_pad_data", 512'(b_m_data[63:0]), 512'(0));
      check("b2_pad_keep", 512'(b_m_keep[7:0]), 512'((k == 7) ? 8'h0F : 8'hFF));
      check("b2_pad_last", 512'(b_m_last[0]), 512'(k == 7));
      check("b2_pad_user", 512'(b_m_user[0]), 512'(k == 7));
      check("b2_pad_ready", 512'(b_s_ready[0]), 512'(k == 7));
    end
    tick();
    check("b2_idle", 512'(b_m_valid[0]), 512'(1'b0));
    check("b2_pad_cnt", 512'(b_pad[31:0]), 512'(StatsEn ? 32'd1 : 32'd0));

    // 512-bit 130-byte frame under random backpressure
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 16; w++) beat_d[b][w*32 +: 32] = $urandom;
    end
    beat_k[0] = '1; beat_k[1] = '1; beat_k[2] = 64'h3;
    in_i = 0; out_i = 0; stall = 1'b0;
    hold_d = '0; hold_k = '0; hold_l = 1'b0;
    for (int cyc = 0; cyc < 400 && out_i < 3; cyc++) begin
      a_m_ready = 1'($urandom_range(0, 1));
      a_s_valid = (in_i < 3);
      if (in_i < 3) begin
        a_s_data = beat_d[in_i];
        a_s_keep = beat_k[in_i];
        a_s_last = (in_i == 2);
      end
      #2;
      if (stall) begin
        check("a3_stall_valid", 512'(a_m_valid), 512'(1'b1));
        check("a3_stall_data", a_m_data, hold_d);
        check("a3_stall_keep", 512'(a_m_keep), 512'(hold_k));
        check("a3_stall_last", 512'(a_m_last), 512'(hold_l));
      end
      stall = a_m_valid && !a_m_ready;
      hold_d = a_m_data; hold_k = a_m_keep; hold_l = a_m_last;
      if (a_m_valid && a_m_ready) begin
        got_d[out_i] = a_m_data; got_k[out_i] = a_m_keep; got_l[out_i] = a_m_last;
        out_i++;
      end
      if (a_s_valid && a_s_ready) in_i++;
      tick();
    end
    a_s_valid = 1'b0; a_s_last = 1'b0; a_m_ready = 1'b1;
    check("a3_beats", 512'(out_i), 512'(3));
    check("a3_no_dup", 512'(a_m_valid), 512'(1'b0));
    if (out_i == 3) begin
      exp_d = '0;
      exp_d[15:0] = beat_d[2][15:0];
      check("a3_b0_data", got_d[0], beat_d[0]);
      check("a3_b1_data", got_d[1], beat_d[1]);
      check("a3_b2_data", got_d[2], exp_d);
      check("a3_b0_keep", 512'(got_k[0]), 512'({64{1'b1}}));
      check("a3_b2_keep", 512'(got_k[2]), 512'(64'h3));
      check("a3_lasts", 512'({got_l[0], got_l[1], got_l[2]}), 512'(3'b001));
    end
    check("a3_pad", 512'(a_pad), 512'(StatsEn ? 32'd1 : 32'd0));

    // Reset while ch0 is in PAD (after beat 4 of a 24-byte frame)
    b_s_keep = 16'h00FF; b_s_valid = 2'b01; b_s_user = 2'b00;
    b_s_data[63:0] = 64'h1111111111111111; b_s_last = 2'b00;
    tick();
    tick();
    b_s_last = 2'b01;
    tick();
    b_s_valid = 2'b00; b_s_last = 2'b00;
    tick();
    tick();
    check("b4_pre_rst_keep", 512'(b_m_keep[7:0]), 512'(8'hFF));
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("b4_rst_valid", 512'(b_m_valid), 512'(2'b00));
    check("b4_rst_ready", 512'(b_s_ready[0]), 512'(1'b1));
    // 60-byte frame follows unaltered
    b_s_valid = 2'b01;
    for (int j = 0; j < 8; j++) begin
      b_s_data[63:0] = (j == 7) ? 64'hFFEEDDCCBBAA9988 : 64'(j + 1) * 64'h0101010101010101;
      b_s_keep[7:0] = (j == 7) ? 8'h0F : 8'hFF;
      b_s_last[0] = (j == 7);
      tick();
      check("b4_data", 512'(b_m_data[63:0]),
            512'((j == 7) ? 64'h00000000BBAA9988 : 64'(j + 1) * 64'h0101010101010101));
      check("b4_keep", 512'(b_m_keep[7:0]), 512'((j == 7) ? 8'h0F : 8'hFF));
      check("b4_last", 512'(b_m_last[0]), 512'(j == 7));
    end
    b_s_valid = 2'b00; b_s_last = 2'b00;
    tick();
    check("b4_no_pad", 512'(b_m_valid[0]), 512'(1'b0));
    check("b4_pad_cnt", 512'(b_pad[31:0]), 512'(0));

    // ch0 stalled with one beat held; ch1 streams 100 one-byte runts
    b_m_ready = 2'b10;
    b_s_valid = 2'b01; b_s_data[63:0] = 64'hC0FFEE0012345678; b_s_keep[7:0] = 8'hFF;
    b_s_last = 2'b00;
    tick();
    b_s_valid = 2'b00;
    b_s_data[127:64] = 64'h55555555555555A5; b_s_keep[15:8] = 8'h01;
    b_s_last = 2'b10; b_s_user = 2'b00;
    frames = 0; out_last = 0; out_beats = 0;
    for (int cyc = 0; cyc < 2000 && out_last < 100; cyc++) begin
      b_s_valid[1] = (frames < 100);
      #2;
      if (b_m_valid[1] && b_m_ready[1]) begin
        check("b5_ch1_data", 512'(b_m_data[127:64]),
              512'(((out_beats % 8) == 0) ? 64'hA5 : 64'h0));
        out_beats++;
        if (b_m_last[1]) begin
          out_last++;
          check("b5_ch1_last_keep", 512'(b_m_keep[15:8]), 512'(8'h0F));
        end
      end
      if (b_s_valid[1] && b_s_ready[1]) frames++;
      tick();
    end
    b_s_valid = 2'b00; b_s_last = 2'b00;
    check("b5_frames_out", 512'(out_last), 512'(100));
    check("b5_beats_out", 512'(out_beats), 512'(800));
    check("b5_pad_cnt_ch1", 512'(b_pad[63:32]), 512'(StatsEn ? 32'd100 : 32'd0));
    check("b5_ch0_valid", 512'(b_m_valid[0]), 512'(1'b1));
    check("b5_ch0_data", 512'(b_m_data[63:0]), 512'(64'hC0FFEE0012345678));
    check("b5_ch0_ready", 512'(b_s_ready[0]), 512'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
